// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums signed Q16.16 product beats, rounds/saturates to Q8.8.
// Optional overflow flag port out_ovf when DPA_OVF_FLAG_EN is defined.
module dot_product_accumulator #(
  parameter int IN_W       = 32,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int MAX_LEN    = 16,
  parameter int CNT_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
`ifdef DPA_OVF_FLAG_EN
  output logic              out_ovf,
`endif
  output logic              dbg_state
);

  // Handshakes: a beat transfers on a rising CLK when in_valid & in_ready;
  // a result transfers when out_valid & out_ready. Ready/valid are pure
  // functions of the state register, so no input reaches an output combinationally.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   r_state;
  state_t                   w_state_n;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [OUT_W-1:0]         r_data;
  logic [CNT_W-1:0]         r_count;

  logic                     w_beat;
  logic                     w_end;
  logic signed [ACC_W-1:0]  w_acc_n;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic [OUT_W-1:0]         w_res;

  assign w_beat  = in_valid && (r_state == ACCUM);
  // A full vector forces the end even without in_last.
  assign w_end   = in_last || (r_cnt == CNT_W'(MAX_LEN - 1));
  assign w_acc_n = r_acc + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_sum   = w_acc_n + RND_HALF;
  assign w_rnd   = w_sum >>> FRAC_SHIFT;
  assign w_sat_hi = (w_rnd > SAT_MAX);
  assign w_sat_lo = (w_rnd < SAT_MIN);
  assign w_res   = w_sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   w_sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                              w_rnd[OUT_W-1:0];

  always_comb begin
    w_state_n = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (w_beat && w_end) w_state_n = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_n = ACCUM;
      end
      default: w_state_n = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_beat) begin
        if (w_end) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_data  <= w_res;
          r_count <= r_cnt + CNT_W'(1);
        end else begin
          r_acc <= w_acc_n;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef DPA_OVF_FLAG_EN
  logic r_ovf;
  logic w_take;
  assign w_take = out_ready && (r_state == HOLD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (w_beat && w_end) begin
      r_ovf <= w_sat_hi || w_sat_lo;
    end else if (w_take) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_ovf = r_ovf;
`endif

  assign out_data  = r_data;
  assign out_count = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed + random bench for dot_product_accumulator with an expected-result queue.
module tb_dot_product_accumulator;

  localparam int OUT_W = 16;
  localparam int CNT_W = 5;
  localparam int W     = 1 + CNT_W + OUT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              dbg_state;
`ifdef DPA_OVF_FLAG_EN
  logic              out_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  dot_product_accumulator dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
`ifdef DPA_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] d, input logic [CNT_W-1:0] c, input logic ovf);
    exp_q.push_back({ovf, c, d});
  endtask

  // Reference: round half up, floor shift, clamp to 16-bit signed.
  function automatic logic [W-1:0] model(input longint sum, input int cnt);
    longint r;
    logic   ovf;
    r   = (sum + 128) >>> 8;
    ovf = 1'b0;
    if (r > 32767) begin
      r = 32767;
      ovf = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      ovf = 1'b1;
    end
    return {ovf, CNT_W'(cnt), r[15:0]};
  endfunction

  // Driver: present one beat and hold it until accepted.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  '0);
    check("rst_out_count", out_count, '0);
    check("rst_state",     dbg_state, 1'b0);
`ifdef DPA_OVF_FLAG_EN
    check("rst_out_ovf",   out_ovf,   1'b0);
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard: called right after the end beat was accepted.
  task automatic collect(input int stall);
    logic [W-1:0] e;
    int n;
    check("out_valid_latency", out_valid, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 1'b0, 1'b1);
      return;
    end
    e = exp_q.pop_front();
    check("out_data",  out_data,  e[OUT_W-1:0]);
    check("out_count", out_count, e[OUT_W+CNT_W-1:OUT_W]);
`ifdef DPA_OVF_FLAG_EN
    check("out_ovf",   out_ovf,   e[W-1]);
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold_in_ready",  in_ready,  1'b0);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_data",  out_data,  e[OUT_W-1:0]);
      check("hold_out_count", out_count, e[OUT_W+CNT_W-1:OUT_W]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready",  in_ready,  1'b1);
    check("post_out_data",  out_data,  e[OUT_W-1:0]);
`ifdef DPA_OVF_FLAG_EN
    check("post_out_ovf",   out_ovf,   1'b0);
`endif
  endtask

  initial begin
    longint sum;
    int     len;
    int     dd;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    do_reset();

    // 3 x 1.0 -> 3.0
    push_exp(16'h0300, 5'd3, 1'b0);
    send_beat(32'h0001_0000, 1'b0);
    send_beat(32'h0001_0000, 1'b0);
    send_beat(32'h0001_0000, 1'b1);
    collect(0);

    // -1.0 + 0.5 -> -0.5
    push_exp(16'hFF80, 5'd2, 1'b0);
    send_beat(32'hFFFF_0000, 1'b0);
    send_beat(32'h0000_8000, 1'b1);
    collect(0);

    // Half-up rounding at both signs
    push_exp(16'h0001, 5'd1, 1'b0);
    send_beat(32'h0000_0080, 1'b1);
    collect(0);
    push_exp(16'h0000, 5'd1, 1'b0);
    send_beat(32'hFFFF_FF80, 1'b1);
    collect(0);

    // Saturation high and low
    push_exp(16'h7FFF, 5'd2, 1'b1);
    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'h7FFF_FFFF, 1'b1);
    collect(0);
    push_exp(16'h8000, 5'd2, 1'b1);
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'h8000_0000, 1'b1);
    collect(0);

    // Backpressure: upstream keeps offering a beat while the result is held
    push_exp(16'h0100, 5'd1, 1'b0);
    send_beat(32'h0001_0000, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h0002_0000;
    in_last  = 1'b1;
    collect(5);
    push_exp(16'h0200, 5'd1, 1'b0);
    send_beat(32'h0002_0000, 1'b1);
    collect(0);

    // Reset mid-vector discards the partial sum
    send_beat(32'h0001_0000, 1'b0);
    send_beat(32'h0001_0000, 1'b0);
    do_reset();
    push_exp(16'h0100, 5'd1, 1'b0);
    send_beat(32'h0001_0000, 1'b1);
    collect(0);

    // Forced end after 16 beats with no in_last
    push_exp(16'h0010, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send_beat(32'h0000_0100, 1'b0);
    collect(0);

    // Random vectors with idle gaps
    for (int v = 0; v < 8; v++) begin
      len = int'($urandom_range(1, 16));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        dd = int'($urandom_range(0, 33554431)) - 16777216;
        sum += longint'(dd);
        if (i == len - 1) exp_q.push_back(model(sum, len));
        send_beat(32'(dd), (i == len - 1));
        if (i != len - 1) repeat ($urandom_range(0, 2)) tick();
      end
      collect(int'($urandom_range(0, 2)));
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
